// File: rtl/aer_pkg.sv
// Shared AER arbiter definitions: FSM states, event counter width and channel index map.
package aer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    REQ,
    ACK,
    RELEASE
  } aer_state_t;

  localparam int AER_EVT_CNT_W = 16;

  localparam int CH1_UP = 0;
  localparam int CH1_DN = 1;
  localparam int CH2_UP = 2;
  localparam int CH2_DN = 3;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/aer_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N_CH.
module aer_rr_pick
  import aer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] sel,
  output logic             valid
);

  int idx;

  // Scan last+1 .. last+N_CH so the previous winner is considered last.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = wrap_idx(int'(last), i, N_CH);
      if (!valid && |(req & (N_CH'(1) << idx))) begin
        valid = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/aer_channel_arbiter.sv
// Round-robin arbiter sharing one off-chip AER bus among N_CH channel FSMs,
// driving the 4-phase aer_req/aer_ack handshake with a per-phase timeout.
module aer_channel_arbiter
  import aer_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 2,
  parameter int TO_MAX = 255,
  parameter int TO_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req,
  output logic [N_CH-1:0]          gnt,
  output logic                     aer_req,
  output logic [ADDR_W-1:0]        aer_addr,
  input  logic                     aer_ack,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [AER_EVT_CNT_W-1:0] evt_count
);

  aer_state_t state, state_next;

  logic [N_CH-1:0]          gnt_next;
  logic                     aer_req_next;
  logic [ADDR_W-1:0]        aer_addr_next;
  logic                     err_next;
  logic [AER_EVT_CNT_W-1:0] evt_next;
  logic [TO_W-1:0]          tmr, tmr_next, tmr_inc;
  logic [ADDR_W-1:0]        last, last_next;
  logic [ADDR_W-1:0]        sel;
  logic                     sel_valid;
  logic                     timeout_hit;
  logic                     req_granted;

  aer_rr_pick #(
    .N_CH (N_CH),
    .IDX_W(ADDR_W)
  ) u_pick (
    .req  (req),
    .last (last),
    .sel  (sel),
    .valid(sel_valid)
  );

  assign tmr_inc     = tmr + 1'b1;
  // Fires on the edge the timer would reach TO_MAX, i.e. TO_MAX cycles into the phase.
  assign timeout_hit = (tmr_inc == TO_W'(TO_MAX));
  assign req_granted = |(req & gnt);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      aer_req     <= 1'b0;
      aer_addr    <= '0;
      err_timeout <= 1'b0;
      evt_count   <= '0;
      tmr         <= '0;
      last        <= ADDR_W'(N_CH - 1);
    end else begin
      state       <= state_next;
      gnt         <= gnt_next;
      aer_req     <= aer_req_next;
      aer_addr    <= aer_addr_next;
      err_timeout <= err_next;
      evt_count   <= evt_next;
      tmr         <= tmr_next;
      last        <= last_next;
    end
  end

  always_comb begin
    state_next    = state;
    gnt_next      = gnt;
    aer_req_next  = aer_req;
    aer_addr_next = aer_addr;
    err_next      = 1'b0;
    evt_next      = evt_count;
    tmr_next      = tmr;
    last_next     = last;

    case (state)
      IDLE: begin
        if (sel_valid) begin
          gnt_next      = N_CH'(1) << sel;
          aer_addr_next = sel;
          state_next    = GRANT;
        end
      end

      GRANT: begin
        aer_req_next = 1'b1;
        tmr_next     = '0;
        state_next   = REQ;
      end

      REQ: begin
        if (aer_ack) begin
          aer_req_next = 1'b0;
          tmr_next     = '0;
          state_next   = ACK;
        end else if (timeout_hit) begin
          err_next     = 1'b1;
          aer_req_next = 1'b0;
          tmr_next     = '0;
          state_next   = RELEASE;
        end else begin
          tmr_next = tmr_inc;
        end
      end

      ACK: begin
        if (!aer_ack) begin
          evt_next   = evt_count + 1'b1;
          state_next = RELEASE;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          tmr_next   = '0;
          state_next = RELEASE;
        end else begin
          tmr_next = tmr_inc;
        end
      end

      RELEASE: begin
        if (!req_granted) begin
          gnt_next   = '0;
          last_next  = aer_addr;
          state_next = IDLE;
        end
      end

      default: begin
        gnt_next     = '0;
        aer_req_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  a_stable_while_req : assert property (
    @(posedge clk) disable iff (reset)
    (aer_req && $past(aer_req)) |-> ($stable(aer_addr) && $stable(gnt))
  );

endmodule

// File: tb/tb_aer_channel_arbiter.sv
// Directed self-checking bench for aer_channel_arbiter: latency, round-robin order,
// wrap priority, timeout, mid-transaction reset and event counter wrap.
module tb_aer_channel_arbiter;
  import aer_pkg::*;

  localparam int N_CH   = 4;
  localparam int ADDR_W = 2;
  localparam int TO_MAX = 255;
  localparam int TO_W   = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_CH-1:0]          req;
  logic [N_CH-1:0]          gnt;
  logic                     aer_req;
  logic [ADDR_W-1:0]        aer_addr;
  logic                     aer_ack;
  logic                     busy;
  logic                     err_timeout;
  logic [AER_EVT_CNT_W-1:0] evt_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_evt;

  aer_channel_arbiter #(
    .N_CH  (N_CH),
    .ADDR_W(ADDR_W),
    .TO_MAX(TO_MAX),
    .TO_W  (TO_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .gnt        (gnt),
    .aer_req    (aer_req),
    .aer_addr   (aer_addr),
    .aer_ack    (aer_ack),
    .busy       (busy),
    .err_timeout(err_timeout),
    .evt_count  (evt_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    req     = '0;
    aer_ack = 1'b0;
    tick(2);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (aer_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_aer_req: got %b expected 0", aer_req); end
    checks++; if (aer_addr !== 2'd0) begin errors++; $display("[TB] FAIL reset_aer_addr: got %0d expected 0", aer_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_timeout); end
    checks++; if (evt_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_evt: got %h expected 0000", evt_count); end
    reset   = 1'b0;
    exp_evt = 16'h0000;
  endtask

  task automatic test_single_event;
    req = 4'b0001;
    tick(1);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL single_gnt_lat: got %b expected 0001", gnt); end
    checks++; if (aer_req !== 1'b0) begin errors++; $display("[TB] FAIL single_setup_req: got %b expected 0", aer_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    tick(1);
    checks++; if (aer_req !== 1'b1) begin errors++; $display("[TB] FAIL single_req_lat: got %b expected 1", aer_req); end
    checks++; if (aer_addr !== 2'd0) begin errors++; $display("[TB] FAIL single_addr: got %0d expected 0", aer_addr); end
    aer_ack = 1'b1;
    tick(1);
    checks++; if (aer_req !== 1'b0) begin errors++; $display("[TB] FAIL single_req_drop: got %b expected 0", aer_req); end
    aer_ack = 1'b0;
    tick(1);
    exp_evt++;
    checks++; if (evt_count !== exp_evt) begin errors++; $display("[TB] FAIL single_evt: got %h expected %h", evt_count, exp_evt); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL single_gnt_hold: got %b expected 0001", gnt); end
    req = 4'b0000;
    tick(1);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL single_gnt_release: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
  endtask

  // One full handshake expected on channel ch; the channel's req bit is dropped at the end.
  task automatic run_txn(input int ch, input string tag);
    int n;
    logic [3:0] exp_gnt;
    exp_gnt = 4'(1 << ch);
    n = 0;
    while (gnt === 4'b0000 && n < 10) begin
      tick(1);
      n++;
    end
    checks++; if (gnt !== exp_gnt) begin errors++; $display("[TB] FAIL %s_gnt: got %b expected %b", tag, gnt, exp_gnt); end
    tick(1);
    checks++; if (aer_req !== 1'b1 || aer_addr !== 2'(ch)) begin
      errors++; $display("[TB] FAIL %s_req_addr: got req=%b addr=%0d expected req=1 addr=%0d", tag, aer_req, aer_addr, ch);
    end
    aer_ack = 1'b1;
    tick(1);
    aer_ack = 1'b0;
    tick(1);
    exp_evt++;
    checks++; if (evt_count !== exp_evt) begin errors++; $display("[TB] FAIL %s_evt: got %h expected %h", tag, evt_count, exp_evt); end
    tick(2);
    checks++; if (gnt !== exp_gnt) begin errors++; $display("[TB] FAIL %s_gnt_hold: got %b expected %b", tag, gnt, exp_gnt); end
    req[ch] = 1'b0;
    tick(1);
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_release: got gnt=%b busy=%b expected gnt=0000 busy=0", tag, gnt, busy);
    end
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req   = '0;
    tick(1);
    reset   = 1'b0;
    exp_evt = 16'h0000;
    req     = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_txn(order[k], $sformatf("rr%0d", k));
      req[order[k]] = 1'b1;
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap_priority;
    req = 4'b0010;
    run_txn(CH1_DN, "wrap_setup");
    req = 4'b0011;
    run_txn(CH1_UP, "wrap_first");
    run_txn(CH1_DN, "wrap_second");
  endtask

  task automatic test_timeout;
    int n;
    req = 4'b0100;
    n = 0;
    while (aer_req !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    checks++; if (aer_req !== 1'b1 || gnt !== 4'b0100) begin
      errors++; $display("[TB] FAIL to_start: got req=%b gnt=%b expected req=1 gnt=0100", aer_req, gnt);
    end
    n = 0;
    while (err_timeout !== 1'b1 && n < TO_MAX + 10) begin
      tick(1);
      n++;
    end
    checks++; if (n !== TO_MAX) begin errors++; $display("[TB] FAIL to_delay: got %0d expected %0d", n, TO_MAX); end
    checks++; if (aer_req !== 1'b0) begin errors++; $display("[TB] FAIL to_aer_req: got %b expected 0", aer_req); end
    checks++; if (evt_count !== exp_evt) begin errors++; $display("[TB] FAIL to_evt: got %h expected %h", evt_count, exp_evt); end
    tick(1);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse: got %b expected 0", err_timeout); end
    checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL to_gnt_hold: got %b expected 0100", gnt); end
    req = 4'b0000;
    tick(1);
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL to_release: got gnt=%b busy=%b expected gnt=0000 busy=0", gnt, busy);
    end
  endtask

  task automatic test_reset_mid_ack;
    int n;
    req = 4'b1000;
    n = 0;
    while (aer_req !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    aer_ack = 1'b1;
    tick(1);
    checks++; if (busy !== 1'b1 || gnt !== 4'b1000) begin
      errors++; $display("[TB] FAIL mid_in_ack: got busy=%b gnt=%b expected busy=1 gnt=1000", busy, gnt);
    end
    reset = 1'b1;
    req   = 4'b0000;
    tick(1);
    exp_evt = 16'h0000;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL mid_gnt: got %b expected 0000", gnt); end
    checks++; if (aer_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_aer_req: got %b expected 0", aer_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (evt_count !== exp_evt) begin errors++; $display("[TB] FAIL mid_evt: got %h expected %h", evt_count, exp_evt); end
    reset   = 1'b0;
    aer_ack = 1'b0;
    req     = 4'b0100;
    run_txn(CH2_UP, "mid_after");
  endtask

  task automatic test_evt_wrap;
    force dut.evt_count = 16'hFFFF;
    tick(1);
    release dut.evt_count;
    tick(1);
    exp_evt = 16'hFFFF;
    checks++; if (evt_count !== exp_evt) begin errors++; $display("[TB] FAIL wrap_preset: got %h expected %h", evt_count, exp_evt); end
    req = 4'b0001;
    run_txn(CH1_UP, "wrap_evt");
    checks++; if (evt_count !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected 0000", evt_count); end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_round_robin();
    test_wrap_priority();
    test_timeout();
    test_reset_mid_ack();
    test_evt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
